add64_slice_seq: RTL and testbench

//  Multi-cycle 64-bit integer add/subtract unit for the Y86 execute stage.

---
 rtl/y86_alu_pkg.sv | 22 ++
 rtl/add64_slice_seq_adder_16.sv | 42 ++++
 rtl/add64_slice_seq.sv | 119 +++++++++++
 tb/tb_add64_slice_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_alu_pkg.sv
// Shared definitions for the Y86 execute-stage ALU blocks.
package y86_alu_pkg;

  localparam int SLICE_W = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit positions inside the condition-code flag vector.
  localparam int FLAG_ZF = 0;
  localparam int FLAG_SF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_CF = 3;
  localparam int NFLAGS  = 4;

endpackage

// File: rtl/add64_slice_seq_adder_16.sv
// 16-bit Kogge-Stone parallel-prefix adder with carry-in; o[16] is carry-out.
module adder_16
  import y86_alu_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W:0]   o
);

  localparam int LVL = $clog2(SLICE_W);

  logic [LVL:0][SLICE_W-1:0] g;
  logic [LVL:0][SLICE_W-1:0] p;
  logic [SLICE_W:0]          c;

  // Prefix tree over (generate, propagate); cin folded in at the end.
  always_comb begin
    g    = '0;
    p    = '0;
    c    = '0;
    g[0] = a & b;
    p[0] = a ^ b;
    for (int l = 0; l < LVL; l++) begin
      for (int i = 0; i < SLICE_W; i++) begin
        if (i >= (1 << l)) begin
          g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
          p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
        end else begin
          g[l+1][i] = g[l][i];
          p[l+1][i] = p[l][i];
        end
      end
    end
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      c[i+1] = g[LVL][i] | (p[LVL][i] & cin);
    end
    o = {c[SLICE_W], p[0] ^ c[SLICE_W-1:0]};
  end

endmodule

// File: rtl/add64_slice_seq.sv
// Multi-cycle add/subtract: DATA_W operands processed SLICE_W bits per cycle
// through one shared 16-bit adder, carry chained between slices.
module add64_slice_seq
  import y86_alu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zf,
  output logic              out_sf,
  output logic              out_of,
  output logic              out_cf,
  output logic              busy
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;     // already inverted for SUB
  logic [DATA_W-1:0]  res_q, res_d;
  logic [NFLAGS-1:0]  flags_q, flags_d;

  logic [SLICE_W-1:0] slice_a, slice_b;
  logic [SLICE_W:0]   slice_o;

  // Slice mux into the single adder instance.
  assign slice_a = a_q[cnt_q*SLICE_W +: SLICE_W];
  assign slice_b = b_q[cnt_q*SLICE_W +: SLICE_W];

  adder_16 u_add (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_q),
    .o   (slice_o)
  );

  // Next-state: operand capture, slice demux into result, flags on last slice.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = (in_op == OP_SUB) ? ~in_b : in_b;
          carry_d = (in_op == OP_SUB);
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[cnt_q*SLICE_W +: SLICE_W] = slice_o[SLICE_W-1:0];
        carry_d = slice_o[SLICE_W];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NSLICE - 1)) begin
          flags_d[FLAG_ZF] = (res_d == '0);
          flags_d[FLAG_SF] = res_d[DATA_W-1];
          flags_d[FLAG_CF] = slice_o[SLICE_W];
          flags_d[FLAG_OF] = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                             (res_d[DATA_W-1] != a_q[DATA_W-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_result = res_q;
  assign out_zf     = flags_q[FLAG_ZF];
  assign out_sf     = flags_q[FLAG_SF];
  assign out_of     = flags_q[FLAG_OF];
  assign out_cf     = flags_q[FLAG_CF];

endmodule

// File: tb/tb_add64_slice_seq.sv
// Bench for add64_slice_seq: table vectors, hold/reset corner cases, random ops.
module tb_add64_slice_seq;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  fl;   // {cf, of, sf, zf}
  } exp_t;

  typedef struct {
    logic        op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [3:0]  fl;
  } tv_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_zf, out_sf, out_of, out_cf;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   n_in   = 0;
  int   n_out  = 0;
  bit   bp_mode = 1'b0;
  exp_t sb[$];
  tv_t  tv[10];

  always #5 clk = ~clk;

  add64_slice_seq #(.DATA_W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zf     (out_zf),
    .out_sf     (out_sf),
    .out_of     (out_of),
    .out_cf     (out_cf),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference: unsigned 65-bit sum for result/carry, 66-bit signed math for overflow.
  function automatic exp_t model(input logic op, input logic [63:0] a, input logic [63:0] b);
    exp_t               e;
    logic [64:0]        u;
    logic signed [65:0] s;
    logic               cf;
    if (!op) begin
      u  = {1'b0, a} + {1'b0, b};
      s  = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
      cf = u[64];
    end else begin
      u  = {1'b0, a} - {1'b0, b};
      s  = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
      cf = (a >= b);
    end
    e.res = u[63:0];
    e.fl  = {cf, (s[64] != s[63]), u[63], (u[63:0] == 64'd0)};
    return e;
  endfunction

  task automatic send(input logic op, input logic [63:0] a, input logic [63:0] b, input exp_t e);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        n_in++;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("accept");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      timeout("drain");
      sb.delete();
    end
  endtask

  initial begin
    exp_t e;
    int   lat;
    rst = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

    tv[0] = '{1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000, 4'b0000};
    tv[1] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 4'b0110};
    tv[2] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1010};
    tv[3] = '{1'b1, 64'h5, 64'h5, 64'h0, 4'b1001};
    tv[4] = '{1'b1, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010};
    tv[5] = '{1'b1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1100};
    tv[6] = '{1'b0, 64'h0000_FFFF_FFFF_FFFF, 64'h1, 64'h0001_0000_0000_0000, 4'b0000};
    tv[7] = '{1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0001_0000_0000, 4'b0000};
    tv[8] = '{1'b1, 64'h0001_0000_0000_0000, 64'h1, 64'h0000_FFFF_FFFF_FFFF, 4'b1000};
    tv[9] = '{1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 4'b1101};

    // Output monitor: a handshake seen here completes on the next rising edge.
    fork
      forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h expected none", out_result);
          end else begin
            exp_t me;
            me = sb.pop_front();
            n_out++;
            chk("result", out_result, me.res);
            chk("flags", {60'd0, out_cf, out_of, out_sf, out_zf}, {60'd0, me.fl});
          end
        end
      end
      forever begin
        @(posedge clk); #2;
        if (bp_mode) out_ready = 1'($urandom_range(0, 1));
      end
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_result", out_result, 64'd0);
    chk("rst_flags", {60'd0, out_cf, out_of, out_sf, out_zf}, 64'd0);
    @(posedge clk); #1;

    // Table vectors with latency measurement
    for (int i = 0; i < 10; i++) begin
      e.res = tv[i].res;
      e.fl  = tv[i].fl;
      send(tv[i].op, tv[i].a, tv[i].b, e);
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (out_valid) begin
          lat = k;
          break;
        end
      end
      chk("latency", 64'(lat), 64'd4);
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      drain();
    end

    // Hold in DONE with a competing request pending
    e.res = 64'd3; e.fl = 4'b0000;
    send(1'b0, 64'd1, 64'd2, e);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = 1;
        break;
      end
    end
    if (lat == 0) timeout("hold_wait");
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 1'b0; in_a = 64'd10; in_b = 64'd20;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_result", out_result, 64'd3);
      chk("hold_flags", {60'd0, out_cf, out_of, out_sf, out_zf}, 64'd0);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("second_accept_ready", {63'd0, in_ready}, 64'd1);
    if (in_ready) begin
      e.res = 64'd30; e.fl = 4'b0000;
      sb.push_back(e);
      n_in++;
    end
    @(posedge clk); #1 in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    @(posedge clk); #1 out_ready = 1'b0;
    @(posedge clk); #1;

    // Reset during RUN at cnt==2
    e.res = 64'd0; e.fl = 4'b0000;
    send(1'b0, 64'hFFFF, 64'h1234, e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    n_in--;
    @(negedge clk);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_result", out_result, 64'd0);
    @(posedge clk); #1;
    e.res = 64'd7; e.fl = 4'b0000;
    send(1'b0, 64'd3, 64'd4, e);
    out_ready = 1'b1;
    drain();
    @(posedge clk); #1 out_ready = 1'b0;
    @(posedge clk); #1;

    // Random ops under random backpressure
    bp_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic        rop;
      logic [63:0] ra, rb;
      rop = 1'($urandom_range(0, 1));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: ra = 64'hFFFF_FFFF_FFFF_FFFF;
        1: rb = 64'h1;
        2: rb = ra;
        3: ra = 64'h8000_0000_0000_0000;
        default: ;
      endcase
      send(rop, ra, rb, model(rop, ra, rb));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    bp_mode = 1'b0;
    @(posedge clk); #3 out_ready = 1'b0;
    repeat (3) @(posedge clk);
    chk("handshake_count", 64'(n_out), 64'(n_in));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
